// File: rtl/aperture_xlate_if.sv
// A8-side and SDRAM-side signal bundle for the aperture translator.
// slave: translator view; master: bus/decoder/SDRAM-controller view.
interface aperture_xlate_if;
    logic        a8_rw_n;
    logic [7:0]  a8_data;
    logic [15:0] addr;
    logic        aValid;
    logic        wValid;
    logic        inRange;
    logic [23:0] baseAddr;
    logic [7:0]  loPage;
    logic        mem_req;
    logic        mem_we;
    logic [23:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        mem_ack;
    logic [7:0]  mem_rdata;
    logic [7:0]  rdData;
    logic        rdValid;
    logic        busy;
    logic        timeoutErr;

    modport slave (
        input  a8_rw_n,
        input  a8_data,
        input  addr,
        input  aValid,
        input  wValid,
        input  inRange,
        input  baseAddr,
        input  loPage,
        output mem_req,
        output mem_we,
        output mem_addr,
        output mem_wdata,
        input  mem_ack,
        input  mem_rdata,
        output rdData,
        output rdValid,
        output busy,
        output timeoutErr
    );

    modport master (
        output a8_rw_n,
        output a8_data,
        output addr,
        output aValid,
        output wValid,
        output inRange,
        output baseAddr,
        output loPage,
        input  mem_req,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata,
        output mem_ack,
        output mem_rdata,
        input  rdData,
        input  rdValid,
        input  busy,
        input  timeoutErr
    );
endinterface

// File: rtl/aperture_xlate.sv
// Translates A8 aperture hits into one SDRAM request/ack transaction
// per bus cycle, with a bounded wait on the controller's acknowledge.
module aperture_xlate #(
    parameter int unsigned TIMEOUT = 15
) (
    input logic              clk,
    input logic              a8_rst,
    aperture_xlate_if.slave  bus
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD      = 3'd1,
        WR_WAIT = 3'd2,
        WR      = 3'd3,
        DONE    = 3'd4
    } state_t;

    localparam logic [7:0] TO_LIMIT = 8'(TIMEOUT);
    localparam logic [7:0] CFG_PAGE = 8'hD6;

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        req_q, req_d;
    logic        we_q, we_d;
    logic [23:0] maddr_q, maddr_d;
    logic [7:0]  wdata_q, wdata_d;
    logic [7:0]  rd_q, rd_d;
    logic        rdv_q, rdv_d;
    logic        busy_q, busy_d;
    logic        terr_q, terr_d;

    logic        trig;
    logic [7:0]  page;
    logic [23:0] xaddr;
    logic        acked;
    logic        expired;

    // The config page is owned by the decoder and is never translated.
    assign trig = bus.aValid & bus.inRange
                & (bus.addr[15:8] != CFG_PAGE);

    assign page  = bus.addr[15:8] - bus.loPage;
    assign xaddr = bus.baseAddr + {8'h00, page, bus.addr[7:0]};

    assign acked   = req_q & bus.mem_ack;
    assign expired = req_q & ~bus.mem_ack & (cnt_q == TO_LIMIT);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        req_d   = req_q;
        we_d    = we_q;
        maddr_d = maddr_q;
        wdata_d = wdata_q;
        rd_d    = rd_q;
        rdv_d   = 1'b0;
        terr_d  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (trig) begin
                    maddr_d = xaddr;
                    we_d    = ~bus.a8_rw_n;
                    if (bus.a8_rw_n) begin
                        state_d = RD;
                        req_d   = 1'b1;
                        cnt_d   = 8'd0;
                    end else begin
                        state_d = WR_WAIT;
                    end
                end
            end
            WR_WAIT: begin
                if (bus.wValid) begin
                    state_d = WR;
                    wdata_d = bus.a8_data;
                    req_d   = 1'b1;
                    cnt_d   = 8'd0;
                end else if (!bus.aValid) begin
                    state_d = IDLE;
                end
            end
            RD, WR: begin
                // An ack in the expiry cycle still completes normally.
                if (acked) begin
                    state_d = DONE;
                    req_d   = 1'b0;
                    if (state_q == RD) begin
                        rd_d  = bus.mem_rdata;
                        rdv_d = 1'b1;
                    end
                end else if (expired) begin
                    state_d = DONE;
                    req_d   = 1'b0;
                    terr_d  = 1'b1;
                    if (state_q == RD) begin
                        rd_d  = 8'hFF;
                        rdv_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            DONE: begin
                if (!bus.aValid) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                req_d   = 1'b0;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (a8_rst) begin
            state_q <= IDLE;
            cnt_q   <= 8'd0;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            maddr_q <= 24'd0;
            wdata_q <= 8'd0;
            rd_q    <= 8'hFF;
            rdv_q   <= 1'b0;
            busy_q  <= 1'b0;
            terr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
            we_q    <= we_d;
            maddr_q <= maddr_d;
            wdata_q <= wdata_d;
            rd_q    <= rd_d;
            rdv_q   <= rdv_d;
            busy_q  <= busy_d;
            terr_q  <= terr_d;
        end
    end

    assign bus.mem_req    = req_q;
    assign bus.mem_we     = we_q;
    assign bus.mem_addr   = maddr_q;
    assign bus.mem_wdata  = wdata_q;
    assign bus.rdData     = rd_q;
    assign bus.rdValid    = rdv_q;
    assign bus.busy       = busy_q;
    assign bus.timeoutErr = terr_q;

endmodule

// File: tb/tb_aperture_xlate.sv
// Directed bench for aperture_xlate: SDRAM requests and read data are
// checked against scoreboard queues filled when stimulus is driven.
module tb_aperture_xlate;

    typedef struct packed {
        logic        we;
        logic [23:0] addr;
        logic [7:0]  wdata;
    } req_t;

    logic clk;
    logic a8_rst;
    int   errors;
    int   checks;

    req_t       req_q[$];
    logic [7:0] rd_q[$];

    aperture_xlate_if bus ();

    aperture_xlate #(.TIMEOUT(15)) dut (
        .clk    (clk),
        .a8_rst (a8_rst),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle_bus();
        bus.a8_rw_n   = 1'b1;
        bus.a8_data   = 8'h00;
        bus.addr      = 16'h0000;
        bus.aValid    = 1'b0;
        bus.wValid    = 1'b0;
        bus.inRange   = 1'b0;
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = 8'h00;
    endtask

    task automatic access(input logic rw_n, input logic [15:0] a,
                          input logic [23:0] base, input logic [7:0] lo);
        bus.a8_rw_n  = rw_n;
        bus.addr     = a;
        bus.baseAddr = base;
        bus.loPage   = lo;
        bus.aValid   = 1'b1;
        bus.inRange  = 1'b1;
    endtask

    // Waits (bounded) for mem_req, then pops and compares the request.
    task automatic expect_req(input string tag, input int lat);
        int   n;
        req_t e;
        n = 0;
        while (!bus.mem_req && n < 8) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_req_lat"}, n, lat);
        if (req_q.size() == 0) begin
            chk({tag, "_sb_empty"}, 1, 0);
        end else begin
            e = req_q.pop_front();
            chk({tag, "_addr"}, bus.mem_addr, e.addr);
            chk({tag, "_we"}, bus.mem_we, e.we);
            if (e.we) chk({tag, "_wdata"}, bus.mem_wdata, e.wdata);
        end
    endtask

    task automatic expect_rd(input string tag);
        chk({tag, "_rdValid"}, bus.rdValid, 1'b1);
        if (rd_q.size() == 0) chk({tag, "_rd_empty"}, 1, 0);
        else chk({tag, "_rdData"}, bus.rdData, rd_q.pop_front());
    endtask

    task automatic end_cycle(input string tag);
        bus.aValid  = 1'b0;
        bus.wValid  = 1'b0;
        bus.inRange = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk({tag, "_busy_low"}, bus.busy, 1'b0);
    endtask

    initial begin
        int   n;
        logic seen;

        errors = 0;
        checks = 0;
        bus.baseAddr = 24'h0;
        bus.loPage   = 8'h0;
        idle_bus();
        a8_rst = 1'b1;
        repeat (2) @(negedge clk);
        a8_rst = 1'b0;

        chk("rst_req", bus.mem_req, 1'b0);
        chk("rst_outs", {bus.mem_we, bus.mem_addr, bus.mem_wdata},
            33'h0);
        chk("rst_rd", {bus.rdData, bus.rdValid, bus.busy,
            bus.timeoutErr}, 11'h7F8);

        // Read translation, ack after 3 cycles
        access(1'b1, 16'h4156, 24'h012300, 8'h40);
        req_q.push_back('{we: 1'b0, addr: 24'h012456, wdata: 8'h00});
        rd_q.push_back(8'h5A);
        expect_req("rd", 1);
        chk("rd_busy", bus.busy, 1'b1);
        bus.baseAddr = 24'hABCDEF;
        bus.addr     = 16'h7777;
        @(negedge clk);
        chk("rd_addr_held", bus.mem_addr, 24'h012456);
        @(negedge clk);
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 8'h5A;
        @(negedge clk);
        bus.mem_ack = 1'b0;
        expect_rd("rd");
        chk("rd_req_drop", bus.mem_req, 1'b0);
        seen = 1'b0;
        bus.mem_ack = 1'b1;
        repeat (4) begin
            @(negedge clk);
            seen |= bus.mem_req | bus.rdValid;
        end
        bus.mem_ack = 1'b0;
        chk("rd_no_second", seen, 1'b0);
        end_cycle("rd");

        // Delayed write
        access(1'b0, 16'h4000, 24'h345600, 8'h40);
        seen = 1'b0;
        repeat (4) begin
            @(negedge clk);
            seen |= bus.mem_req;
        end
        chk("wr_no_early_req", seen, 1'b0);
        bus.wValid  = 1'b1;
        bus.a8_data = 8'hC3;
        req_q.push_back('{we: 1'b1, addr: 24'h345600, wdata: 8'hC3});
        expect_req("wr", 1);
        bus.wValid  = 1'b0;
        bus.a8_data = 8'h00;
        bus.mem_ack = 1'b1;
        @(negedge clk);
        bus.mem_ack = 1'b0;
        chk("wr_done", {bus.mem_req, bus.rdValid, bus.timeoutErr}, 3'b000);
        end_cycle("wr");

        // Wrap-around, immediate ack
        access(1'b1, 16'h8190, 24'hFFFF80, 8'h80);
        req_q.push_back('{we: 1'b0, addr: 24'h000110, wdata: 8'h00});
        rd_q.push_back(8'h11);
        expect_req("wrap", 1);
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 8'h11;
        @(negedge clk);
        bus.mem_ack = 1'b0;
        expect_rd("wrap");
        end_cycle("wrap");

        // Read timeout
        access(1'b1, 16'h1234, 24'h000000, 8'h00);
        req_q.push_back('{we: 1'b0, addr: 24'h001234, wdata: 8'h00});
        rd_q.push_back(8'hFF);
        expect_req("to", 1);
        n = 0;
        while (bus.mem_req && n < 40) begin
            n++;
            @(negedge clk);
        end
        chk("to_req_cycles", n, 16);
        chk("to_err", bus.timeoutErr, 1'b1);
        expect_rd("to");
        end_cycle("to");

        // Ack on the 16th cycle: ack wins
        access(1'b1, 16'h1299, 24'h100000, 8'h10);
        req_q.push_back('{we: 1'b0, addr: 24'h100299, wdata: 8'h00});
        rd_q.push_back(8'h66);
        expect_req("late", 1);
        n = 0;
        while (n < 40) begin
            if (bus.mem_req) n++;
            if (n == 16) break;
            @(negedge clk);
        end
        chk("late_still_req", bus.mem_req, 1'b1);
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 8'h66;
        @(negedge clk);
        bus.mem_ack = 1'b0;
        chk("late_no_err", bus.timeoutErr, 1'b0);
        expect_rd("late");
        chk("late_req_drop", bus.mem_req, 1'b0);
        end_cycle("late");

        // Abandoned write
        access(1'b0, 16'h4010, 24'h000000, 8'h40);
        seen = 1'b0;
        repeat (2) begin
            @(negedge clk);
            seen |= bus.mem_req;
        end
        bus.aValid = 1'b0;
        repeat (3) begin
            @(negedge clk);
            seen |= bus.mem_req;
        end
        chk("abandon_noreq", seen, 1'b0);
        chk("abandon_busy", bus.busy, 1'b0);
        end_cycle("abandon");

        // Config page exclusion
        access(1'b1, 16'hD612, 24'h000000, 8'h00);
        seen = 1'b0;
        repeat (5) begin
            @(negedge clk);
            seen |= bus.mem_req | bus.busy;
        end
        chk("cfg_excluded", seen, 1'b0);
        end_cycle("cfg");

        // Reset mid-read
        access(1'b1, 16'h0455, 24'h200000, 8'h00);
        req_q.push_back('{we: 1'b0, addr: 24'h200455, wdata: 8'h00});
        expect_req("rst", 1);
        a8_rst     = 1'b1;
        bus.aValid = 1'b0;
        @(negedge clk);
        a8_rst = 1'b0;
        chk("rstmid_req", bus.mem_req, 1'b0);
        chk("rstmid_outs", {bus.mem_we, bus.mem_addr, bus.mem_wdata},
            33'h0);
        chk("rstmid_rd", {bus.rdData, bus.rdValid, bus.busy,
            bus.timeoutErr}, 11'h7F8);
        seen = 1'b0;
        @(negedge clk);
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 8'h99;
        @(negedge clk);
        bus.mem_ack = 1'b0;
        seen |= bus.rdValid | bus.mem_req;
        repeat (2) begin
            @(negedge clk);
            seen |= bus.rdValid | bus.mem_req;
        end
        chk("rstmid_late_ack", seen, 1'b0);
        chk("rstmid_rdData", bus.rdData, 8'hFF);

        chk("sb_drained", req_q.size() + rd_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/aperture_xlate.md
# aperture_xlate

Bus-to-SDRAM translator on the far side of the aperture decoder. When an A8 access falls inside a configured aperture, this block computes the SDRAM address from the aperture base and page offset, performs one request/acknowledge transaction with the SDRAM controller, and returns read data to the A8 data-bus driver. It handles one transaction per A8 bus cycle and bounds every transaction with a timeout.

## Interface
- `TIMEOUT`, default 15: maximum cycles `mem_req` waits for `mem_ack` before the transaction is abandoned (range 1..255).
- `clk`  in  1  main FPGA clock.
- `a8_rst`  in  1  reset, synchronous, active-high.
- `a8_rw_n`  in  1  A8 read (1) / write (0).
- `a8_data`  in  8  A8 data bus, valid when `wValid` is high.
- `addr`  in  16  A8 address bus.
- `aValid`  in  1  address valid; high for the whole bus cycle.
- `wValid`  in  1  write data valid.
- `inRange`  in  1  aperture hit from the decoder.
- `baseAddr`  in  24  aperture SDRAM base.
- `loPage`  in  8  aperture lowest host page.
- `mem_req`  out  1  SDRAM request.
- `mem_we`  out  1  1 = write.
- `mem_addr`  out  24  SDRAM byte address.
- `mem_wdata`  out  8  write data.
- `mem_ack`  in  1  request accepted; for reads, `mem_rdata` is valid in the same cycle.
- `mem_rdata`  in  8  read data.
- `rdData`  out  8  data for the A8 bus.
- `rdValid`  out  1  one-cycle strobe: `rdData` is updated.
- `busy`  out  1  state is not IDLE.
- `timeoutErr`  out  1  one-cycle strobe on timeout.

## Operation
- **States:** IDLE, RD, WR_WAIT, WR, DONE.
- **Trigger (IDLE):**
  - Condition: `aValid & inRange & (addr[15:8] != 8'hD6)`. Aperture configuration space is never translated.
  - When the trigger fires, the block latches `addr`, `baseAddr` and `loPage`. Later changes to these inputs are ignored until the block returns to IDLE.
- **Address arithmetic:**
  - `mem_addr = baseAddr + {8'h00, addr[15:8]-loPage, addr[7:0]}`, computed mod 2^24.
  - The page subtraction is 8-bit, mod 256.
- **Read path:**
  - IDLE with trigger and `a8_rw_n=1` → RD. `mem_req=1`, `mem_we=0`.
  - RD with `mem_ack` → DONE. `rdData<=mem_rdata`, `rdValid` pulses, `mem_req` drops.
- **Write path:**
  - IDLE with trigger and `a8_rw_n=0` → WR_WAIT.
  - WR_WAIT with `wValid` → WR. `mem_wdata<=a8_data`, `mem_req=1`, `mem_we=1`.
  - WR_WAIT with `aValid=0` and no `wValid` → IDLE. No SDRAM access is made.
  - WR with `mem_ack` → DONE.
- **Timeout:**
  - An 8-bit counter clears when `mem_req` rises and increments every cycle `mem_req` is high without `mem_ack`.
  - If count == `TIMEOUT` and `mem_ack=0`, the block moves to DONE: `mem_req` drops and `timeoutErr` pulses.
  - A read timeout also sets `rdData<=8'hFF` and pulses `rdValid`.
  - If `mem_ack` arrives in the same cycle as the timeout condition, the ack wins and there is no error.
- **DONE:** waits for `aValid=0`, then → IDLE. This guarantees one transaction per bus cycle.
- `mem_ack` is ignored whenever `mem_req=0`.
- `mem_addr`, `mem_we` and `mem_wdata` are stable for the whole time `mem_req` is high.

## Timing
- **Reset values:**
  - State IDLE, counter 0.
  - `mem_req=0`, `mem_we=0`, `mem_addr=0`, `mem_wdata=0`.
  - `rdData=8'hFF`, `rdValid=0`, `busy=0`, `timeoutErr=0`.
- **Reset mid-transaction:** `mem_req` is low on the cycle after the reset edge. A late ack is ignored.
- All outputs are registered.
- **Read latency:**
  - Trigger sampled at edge 0 → `mem_req` high after edge 0.
  - Ack sampled at edge n → `rdValid` high for exactly the cycle after edge n, and `mem_req` low in that same cycle.
  - With an immediate ack: trigger to `rdValid` is 2 cycles.
- **Write latency:** `wValid` sampled at edge k → `mem_req` high after edge k.
- Maximum `mem_req` high time is `TIMEOUT`+1 cycles.
- `busy` goes high the cycle after the trigger and low the cycle after the DONE→IDLE transition.

## Test plan
- **Read translation:** base=0x012300, loPage=0x40, read addr=0x4156, ack with data 0x5A after 3 cycles.
  - `mem_addr=0x012456`, `mem_we=0`.
  - `rdData=0x5A` with a single `rdValid` pulse.
  - No second request while `aValid` stays high.
- **Delayed write:** addr=0x4000, `wValid` 4 cycles after `aValid` with data 0xC3.
  - `mem_req` rises only after `wValid`.
  - `mem_wdata=0xC3`, `mem_we=1`, `mem_addr=baseAddr`.
- **Wrap-around:** base=0xFFFF80, loPage=0x80, addr=0x8190.
  - `mem_addr=0x000110`.
- **Timeout (TIMEOUT=15), read with no ack:**
  - `mem_req` is high for 16 cycles.
  - `timeoutErr` and `rdValid` pulse together, with `rdData=0xFF`.
  - A separate run with the ack on the 16th cycle gives no error.
- **Abandoned write and config exclusion:**
  - Write whose `aValid` drops before `wValid`: no `mem_req`.
  - Access to addr=0xD612 with `inRange=1`: no `mem_req`, `busy` stays 0.
- **Reset mid-read:** assert `a8_rst` while in RD.
  - `mem_req=0` on the next cycle, all outputs at reset values.
  - An ack 2 cycles later produces no `rdValid`.
